// File: rtl/multdiv_ctrl.sv
// HI/LO control for a multi-cycle mult/div unit: stalls the execute stage while an
// operation is in flight and commits the unit's result into the architectural HI/LO.
module multdiv_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flushE,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] unit_hi,
    input  logic [31:0] unit_lo
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;
    localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q, unit_a_q, unit_b_q;
    logic [1:0]  unit_op_q;
    logic        start_q;

    logic is_md, accept, in_busy, last;

    always_comb begin
        is_md   = (req_op >= OP_MULT) && (req_op <= OP_DIVU);
        in_busy = (state_q == BUSY);
        accept  = !in_busy && req_valid && is_md && !flushE;
        last    = in_busy && (cnt_q == 6'd1);
    end

    // Accept cycle counts as the first stalled cycle, so BUSY only stalls while cnt != 1.
    assign stall      = accept || (in_busy && (cnt_q != 6'd1));
    assign busy       = in_busy;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign unit_start = start_q;
    assign unit_op    = unit_op_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            unit_op_q <= 2'd0;
            unit_a_q  <= 32'd0;
            unit_b_q  <= 32'd0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= BUSY;
                        start_q   <= 1'b1;
                        unit_op_q <= 2'(req_op - OP_MULT);
                        unit_a_q  <= a;
                        unit_b_q  <= b;
                        cnt_q     <= (req_op < 3'd3) ? MULT_CNT : DIV_CNT;
                    end else if (req_valid && !flushE && req_op == OP_MTHI) begin
                        hi_q <= a;
                    end else if (req_valid && !flushE && req_op == OP_MTLO) begin
                        lo_q <= a;
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        state_q <= IDLE;
                        cnt_q   <= 6'd0;
                    end else if (last) begin
                        state_q <= IDLE;
                        cnt_q   <= 6'd0;
                        hi_q    <= unit_hi;
                        lo_q    <= unit_lo;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a vector table of single operations plus
// hand-written flush, pending-MTHI, reset and back-to-back sequences.
module tb_multdiv_ctrl;
    logic        clk = 1'b0;
    logic        reset, req_valid, flushE;
    logic [2:0]  req_op;
    logic [31:0] a, b;
    logic        stall, busy, unit_start;
    logic [31:0] hi, lo, unit_a, unit_b;
    logic [1:0]  unit_op;
    logic [31:0] unit_hi, unit_lo;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    multdiv_ctrl #(.MULT_LAT(5), .DIV_LAT(34)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .a(a), .b(b), .flushE(flushE), .stall(stall), .busy(busy),
        .hi(hi), .lo(lo), .unit_start(unit_start), .unit_op(unit_op),
        .unit_a(unit_a), .unit_b(unit_b), .unit_hi(unit_hi), .unit_lo(unit_lo)
    );

    // Datapath stub: MIPS semantics, HI=remainder LO=quotient; /0 returns hi=a lo=all-ones.
    logic [63:0] prod;
    always_comb begin
        prod    = 64'd0;
        unit_hi = 32'd0;
        unit_lo = 32'd0;
        case (unit_op)
            2'd0: prod = $signed(unit_a) * $signed(unit_b);
            2'd1: prod = {32'd0, unit_a} * {32'd0, unit_b};
            default: prod = 64'd0;
        endcase
        if (unit_op < 2'd2) begin
            unit_hi = prod[63:32];
            unit_lo = prod[31:0];
        end else if (unit_b == 32'd0) begin
            unit_hi = unit_a;
            unit_lo = 32'hFFFF_FFFF;
        end else if (unit_op == 2'd2) begin
            unit_hi = $signed(unit_a) % $signed(unit_b);
            unit_lo = $signed(unit_a) / $signed(unit_b);
        end else begin
            unit_hi = unit_a % unit_b;
            unit_lo = unit_a / unit_b;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        flush;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat;
        logic [1:0]  uop;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        req_valid = 1'b1;
        req_op    = op;
        a         = va;
        b         = vb;
    endtask

    // Returns at the negedge of the first non-stalled cycle; n = stalled cycles seen.
    task automatic wait_final(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) return;
            n++;
            tick();
        end
        chk("final_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input vec_t v);
        int nst = 0;
        int nstart = 0;
        logic done = 1'b0;
        issue(v.op, v.a, v.b);
        flushE = v.flush;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (unit_start) begin
                nstart++;
                chk("unit_op", 64'(unit_op), 64'(v.uop));
            end
            if (stall) nst++;
            else done = 1'b1;
            tick();
        end
        chk("op_timeout", 64'(done), 64'd1);
        req_valid = 1'b0;
        req_op    = 3'd0;
        flushE    = 1'b0;
        @(negedge clk);
        chk("stall_cycles", 64'(nst), 64'(v.lat));
        chk("start_pulses", 64'(nstart), (v.lat > 0) ? 64'd1 : 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("hi", 64'(hi), 64'(v.ehi));
        chk("lo", 64'(lo), 64'(v.elo));
        tick();
    endtask

    initial begin
        int n;
        tbl[0]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h1,         32'hFFFF_FFFE, 5,  2'd1};
        tbl[1]  = '{3'd6, 32'h1234,      32'd0, 1'b0, 32'h1,         32'h1234,      0,  2'd0};
        tbl[2]  = '{3'd5, 32'hCAFE,      32'd0, 1'b0, 32'hCAFE,      32'h1234,      0,  2'd0};
        tbl[3]  = '{3'd3, 32'd7,         32'd2, 1'b0, 32'h1,         32'h3,         34, 2'd2};
        tbl[4]  = '{3'd1, 32'hFFFF_FFFD, 32'd4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5,  2'd0};
        tbl[5]  = '{3'd4, 32'd100,       32'd7, 1'b0, 32'h2,         32'hE,         34, 2'd3};
        tbl[6]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 2'd2};
        tbl[7]  = '{3'd4, 32'd5,         32'd0, 1'b0, 32'h5,         32'hFFFF_FFFF, 34, 2'd3};
        tbl[8]  = '{3'd7, 32'h99,        32'd1, 1'b0, 32'h5,         32'hFFFF_FFFF, 0,  2'd0};
        tbl[9]  = '{3'd0, 32'h98,        32'd1, 1'b0, 32'h5,         32'hFFFF_FFFF, 0,  2'd0};
        tbl[10] = '{3'd1, 32'd3,         32'd3, 1'b1, 32'h5,         32'hFFFF_FFFF, 0,  2'd0};
        tbl[11] = '{3'd6, 32'h77,        32'd0, 1'b1, 32'h5,         32'hFFFF_FFFF, 0,  2'd0};

        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; a = 32'd0; b = 32'd0; flushE = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(unit_start), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_unit", {30'd0, unit_op, unit_a ^ unit_b}, 64'd0);
        tick();

        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        // Flush in BUSY cycle 3 of a DIV: no commit, back to IDLE.
        issue(3'd3, 32'd7, 32'd2);
        @(negedge clk);
        repeat (3) tick();
        chk("divflush_busy", 64'(busy), 64'd1);
        flushE = 1'b1; req_valid = 1'b0;
        tick();
        flushE = 1'b0;
        @(negedge clk);
        chk("divflush_idle", 64'(busy), 64'd0);
        chk("divflush_stall", 64'(stall), 64'd0);
        chk("divflush_hilo", {hi, lo}, {32'h5, 32'hFFFF_FFFF});
        tick();

        // Flush on the final MULT cycle suppresses the commit.
        issue(3'd1, 32'd3, 32'd4);
        wait_final(n);
        chk("mflush_stalls", 64'(n), 64'd5);
        chk("mflush_final_busy", 64'(busy), 64'd1);
        flushE = 1'b1;
        tick();
        flushE = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("mflush_busy", 64'(busy), 64'd0);
        chk("mflush_hilo", {hi, lo}, {32'h5, 32'hFFFF_FFFF});
        tick();

        // MTHI presented while BUSY stays pending until IDLE.
        issue(3'd1, 32'd6, 32'd7);
        @(negedge clk);
        tick();
        req_op = 3'd5; a = 32'hBEEF;
        wait_final(n);
        chk("mthi_pend_stalls", 64'(n), 64'd4);
        chk("mthi_pend_hold", 64'(hi), 64'h5);
        tick();
        @(negedge clk);
        chk("mthi_commit_hilo", {hi, lo}, {32'h0, 32'd42});
        chk("mthi_idle_stall", 64'(stall), 64'd0);
        chk("mthi_idle_busy", 64'(busy), 64'd0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("mthi_written", {hi, lo}, {32'hBEEF, 32'd42});
        tick();

        // Reset mid-MULT clears everything; the next MULT runs normally.
        issue(3'd1, 32'd6, 32'd7);
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b1; req_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ctl", {61'd0, stall, busy, unit_start}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_unit", {30'd0, unit_op, unit_a | unit_b}, 64'd0);
        tick();
        run_op('{3'd1, 32'd3, 32'd5, 1'b0, 32'h0, 32'd15, 5, 2'd0});

        // Back-to-back: new op accepted the cycle right after the final cycle.
        issue(3'd2, 32'd2, 32'd3);
        wait_final(n);
        tick();
        issue(3'd4, 32'd9, 32'd4);
        @(negedge clk);
        chk("b2b_busy", 64'(busy), 64'd0);
        chk("b2b_stall", 64'(stall), 64'd1);
        chk("b2b_hilo", {hi, lo}, {32'h0, 32'd6});
        tick();
        @(negedge clk);
        chk("b2b_start", 64'(unit_start), 64'd1);
        chk("b2b_unit", {30'd0, unit_op, unit_a}, {30'd0, 2'd3, 32'd9});
        flushE = 1'b1; req_valid = 1'b0;
        tick();
        flushE = 1'b0;
        @(negedge clk);
        chk("b2b_flush", {31'd0, busy, hi}, {31'd0, 1'b0, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, meaning BUSY cycles for MULT/MULTU (legal 1..63).
REQ-002 SHALL have parameter DIV_LAT, default 34, meaning BUSY cycles for DIV/DIVU (legal 1..63).
REQ-003 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  the execute stage holds a HI/LO-class instruction.
REQ-006 SHALL have port req_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
REQ-007 SHALL have port a  input  32  rs operand.
REQ-008 SHALL have port b  input  32  rt operand.
REQ-009 SHALL have port flushE  input  1  kill the execute-stage instruction and any operation in flight.
REQ-010 SHALL have port stall  output  1  hold the execute stage this cycle.
REQ-011 SHALL have port busy  output  1  an operation is in flight.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.
REQ-014 SHALL have port unit_start  output  1  one-cycle start pulse to the mult/div datapath.
REQ-015 SHALL have port unit_op  output  2  latched op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-016 SHALL have port unit_a  output  32  latched operand a.
REQ-017 SHALL have port unit_b  output  32  latched operand b.
REQ-018 SHALL have port unit_hi  input  32  datapath HI result, valid on the final BUSY cycle.
REQ-019 SHALL have port unit_lo  input  32  datapath LO result, valid on the final BUSY cycle.

Function
REQ-020 SHALL implement two states, IDLE and BUSY, plus a 6-bit down-counter cnt.
REQ-021 SHALL accept an operation in IDLE when req_valid=1, op is 1..4 and flushE=0: latch unit_op/unit_a/unit_b, set cnt = MULT_LAT (ops 1-2) or DIV_LAT (ops 3-4), and move to BUSY.
REQ-022 SHALL assert unit_start for exactly the first BUSY cycle.
REQ-023 SHALL decrement cnt on each BUSY cycle; the cycle with cnt==1 is the final cycle.
REQ-024 SHALL, at the edge ending the final cycle, write hi<=unit_hi and lo<=unit_lo and return to IDLE, unless flushE=1 in that cycle.
REQ-025 SHALL drive stall = (IDLE & req_valid & op in 1..4 & ~flushE) | (BUSY & cnt!=1), i.e. exactly LAT stalled cycles per accepted op, counted from the accept cycle.
REQ-026 SHALL drive busy = (state==BUSY).
REQ-027 SHALL, for MTHI/MTLO in IDLE with flushE=0, write hi<=a or lo<=a respectively at the clock edge, with no stall and no unit_start.
REQ-028 SHALL ignore MTHI/MTLO while BUSY; the stall keeps them pending until IDLE.
REQ-029 SHALL, on flushE=1 in BUSY (any cycle, including the final one), return to IDLE, clear cnt and leave hi and lo unchanged.
REQ-030 SHALL, on flushE=1 in IDLE, accept nothing and write nothing.
REQ-031 SHALL present hi and lo directly from registers, so MFHI/MFLO read them without a stall and see a committed result in the cycle after the final cycle.
REQ-032 SHALL treat divide-by-zero as a normal DIV_LAT operation and commit whatever the unit returns.
REQ-033 SHALL allow a new op to be accepted in the cycle immediately after the final cycle (back-to-back).

Reset
REQ-034 SHALL, while reset=1 at a rising edge, force: state=IDLE, cnt=0, hi=0, lo=0, unit_op=0, unit_a=0, unit_b=0; stall, busy and unit_start therefore read 0.
REQ-035 SHALL give reset priority over flushE and over any commit, including reset asserted mid-operation.

Verification
REQ-036 SHALL cover: MULTU a=0xFFFFFFFF b=2 accepted at cycle T -> stall high T..T+4, unit_start at T+1, hi=1 lo=0xFFFFFFFE from T+6.
REQ-037 SHALL cover: DIV, unit returns hi=1 lo=3 -> stall high for 34 cycles, commit after the final cycle, busy low the next cycle.
REQ-038 SHALL cover: flushE at BUSY cycle 3 of a DIV -> IDLE next cycle, hi/lo keep their prior values, stall low.
REQ-039 SHALL cover: flushE on the final cycle of MULT -> no commit to hi/lo.
REQ-040 SHALL cover: MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle with no stall; MTHI presented while BUSY -> written only after return to IDLE.
REQ-041 SHALL cover: reset asserted mid-MULT -> all outputs 0 next cycle; next MULT proceeds normally.
